// File: rtl/velocity_cell_dbuf_if.sv
// Bundle of read, write and swap signals for the double-buffered velocity cell.
// Handshake rules:
//   read  : a request is taken on a rising edge where rd_en=1 and rd_ready=1.
//           Exactly one cycle later rd_valid pulses for one cycle with rd_data.
//           rd_en while rd_ready=0 is ignored, and rd_data holds its last value.
//   write : a word is taken on a rising edge where wr_en=1 and wr_ready=1.
//           No response is returned. wr_en while the shadow bank is full sets
//           the sticky overflow flag.
//   swap  : swap_req is sampled only in IDLE. swap_done pulses for one cycle
//           when active_bank and active_count have taken their new values.
interface velocity_cell_dbuf_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  swap_req;
  logic                  swap_done;
  logic                  active_bank;
  logic [ADDR_WIDTH-1:0] active_count;
  logic                  overflow;
  logic [1:0]            dbg_state;

  modport master (
    output rd_en, rd_addr, wr_en, wr_data, swap_req,
    input  rd_ready, rd_valid, rd_data, wr_ready, swap_done,
    input  active_bank, active_count, overflow, dbg_state
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_data, swap_req,
    output rd_ready, rd_valid, rd_data, wr_ready, swap_done,
    output active_bank, active_count, overflow, dbg_state
  );
endinterface

// File: rtl/velocity_cell_dbuf.sv
// Double-buffered velocity store. Reads are served from the active bank, and
// writes are appended into the shadow bank. A swap promotes the shadow bank to
// active after one drain cycle, which lets an in-flight read complete.
module velocity_cell_dbuf #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input logic                 clk,
  input logic                 rst,
  velocity_cell_dbuf_if.slave bus
);

  // The pointer needs one extra bit so it can hold PARTICLE_NUM even when
  // PARTICLE_NUM equals 2^ADDR_WIDTH.
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_FULL = PW'(PARTICLE_NUM);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWAP  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  bank_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic [PW-1:0]         ptr_q;
  logic                  ovf_q;
  logic                  rd_valid_q;
  logic                  swap_done_q;
  logic                  sel_mem_q;
  logic [DATA_WIDTH-1:0] meta_q;
  logic [DATA_WIDTH-1:0] mem_q;

  logic [DATA_WIDTH-1:0] bank0 [PARTICLE_NUM];
  logic [DATA_WIDTH-1:0] bank1 [PARTICLE_NUM];

  logic idle, full, rd_acc, wr_acc, wr_ovf, addr_zero, addr_beyond;

  assign idle        = (state_q == ST_IDLE);
  assign full        = (ptr_q == PTR_FULL);
  assign rd_acc      = bus.rd_en & idle;
  assign wr_acc      = bus.wr_en & idle & ~full;
  assign wr_ovf      = bus.wr_en & idle & full;
  assign addr_zero   = (bus.rd_addr == '0);
  assign addr_beyond = (bus.rd_addr > count_q);

  // Next-state logic: IDLE -> DRAIN -> SWAP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.swap_req) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_SWAP;
      ST_SWAP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control registers: FSM, bank select, count, pointer, flags and read metadata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bank_q      <= 1'b0;
      count_q     <= '0;
      ptr_q       <= PTR_ONE;
      ovf_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      swap_done_q <= 1'b0;
      sel_mem_q   <= 1'b0;
      meta_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_valid_q  <= rd_acc;
      swap_done_q <= (state_q == ST_SWAP);
      if (wr_acc) ptr_q <= ptr_q + PTR_ONE;
      if (wr_ovf) ovf_q <= 1'b1;
      // Writes are only taken in IDLE, so they never collide with the swap update.
      if (state_q == ST_SWAP) begin
        bank_q  <= ~bank_q;
        count_q <= ADDR_WIDTH'(ptr_q - PTR_ONE);
        ptr_q   <= PTR_ONE;
      end
      // Address 0 returns the count, and addresses past the count return zero,
      // so stale memory words are never visible.
      if (rd_acc) begin
        sel_mem_q <= ~addr_zero & ~addr_beyond;
        meta_q    <= addr_zero ? DATA_WIDTH'(count_q) : '0;
      end
    end
  end

  // Bank storage: append into the shadow bank, and do a registered read of the active bank.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      if (bank_q) bank0[ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
      else        bank1[ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end
    if (rd_acc) mem_q <= bank_q ? bank1[bus.rd_addr] : bank0[bus.rd_addr];
  end

  assign bus.rd_ready     = idle;
  assign bus.wr_ready     = idle & ~full;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = sel_mem_q ? mem_q : meta_q;
  assign bus.swap_done    = swap_done_q;
  assign bus.active_bank  = bank_q;
  assign bus.active_count = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_velocity_cell_dbuf.sv
// Bench for velocity_cell_dbuf. It compares the DUT every cycle against a
// queue-based model of the active and shadow banks.
module tb_velocity_cell_dbuf;
  localparam int DW = 96;
  localparam int PN = 220;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  velocity_cell_dbuf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  velocity_cell_dbuf #(
    .DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] act_q[$];
  logic [DW-1:0] shd_q[$];
  logic [DW-1:0] exp_q[$];
  bit            m_bank, m_ovf, m_rd_valid, m_swap_done;
  int            m_busy;
  logic [DW-1:0] m_rd_data;

  function automatic void model_reset();
    act_q.delete(); shd_q.delete(); exp_q.delete();
    m_bank = 0; m_ovf = 0; m_busy = 0;
    m_rd_valid = 0; m_swap_done = 0; m_rd_data = '0;
  endfunction

  function automatic void model_edge();
    logic [DW-1:0] d;
    int a;
    m_rd_valid  = 0;
    m_swap_done = 0;
    if (m_busy == 0) begin
      if (bus.rd_en) begin
        a = int'(bus.rd_addr);
        if (a == 0) d = DW'(act_q.size());
        else if (a <= act_q.size()) d = act_q[a-1];
        else d = '0;
        m_rd_valid = 1;
        m_rd_data  = d;
        exp_q.push_back(d);
      end
      if (bus.wr_en) begin
        if (shd_q.size() < PN - 1) shd_q.push_back(bus.wr_data);
        else m_ovf = 1;
      end
      if (bus.swap_req) m_busy = 2;
    end else begin
      m_busy--;
      if (m_busy == 0) begin
        act_q = shd_q;
        shd_q.delete();
        m_bank = ~m_bank;
        m_swap_done = 1;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_outputs();
    check("rd_ready", DW'(bus.rd_ready), DW'(m_busy == 0));
    check("wr_ready", DW'(bus.wr_ready), DW'((m_busy == 0) && (shd_q.size() < PN - 1)));
    check("rd_valid", DW'(bus.rd_valid), DW'(m_rd_valid));
    check("rd_data", bus.rd_data, m_rd_data);
    check("swap_done", DW'(bus.swap_done), DW'(m_swap_done));
    check("active_bank", DW'(bus.active_bank), DW'(m_bank));
    check("active_count", DW'(bus.active_count), DW'(act_q.size()));
    check("overflow", DW'(bus.overflow), DW'(m_ovf));
    if (bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) check("sb_underflow", DW'(1), DW'(0));
      else check("sb_data", bus.rd_data, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit re, input int addr, input bit we,
                       input logic [DW-1:0] wd, input bit sw);
    bus.rd_en    = re;
    bus.rd_addr  = AW'(addr);
    bus.wr_en    = we;
    bus.wr_data  = wd;
    bus.swap_req = sw;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    drive(0, 0, 0, '0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("dbg_state_rst", DW'(bus.dbg_state), DW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();
  endtask

  task automatic do_swap();
    drive(0, 0, 0, '0, 1);
    step();
    drive(0, 0, 0, '0, 0);
    for (int i = 0; i < 4 && m_busy != 0; i++) step();
    idle_cycles(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(0, 0, 0, '0, 0);
    do_reset();

    // Reads right after reset: address 0 and address 5 both return zero.
    drive(1, 0, 0, '0, 0); step();
    drive(1, 5, 0, '0, 0); step();
    idle_cycles(2);

    // Three writes, a swap, then a read sweep over addresses 1..4 and 0.
    for (int i = 0; i < 3; i++) begin drive(0, 0, 1, rand_word(), 0); step(); end
    do_swap();
    for (int a = 1; a <= 4; a++) begin drive(1, a, 0, '0, 0); step(); end
    drive(1, 0, 0, '0, 0); step();
    idle_cycles(2);

    // Swap together with a write, then a second swap_req during DRAIN.
    for (int i = 0; i < 2; i++) begin drive(0, 0, 1, rand_word(), 0); step(); end
    drive(0, 0, 1, rand_word(), 1); step();
    drive(0, 0, 1, rand_word(), 1); step();
    idle_cycles(4);

    // Reads every cycle while a swap goes through.
    for (int i = 0; i < 4; i++) begin drive(0, 0, 1, rand_word(), 0); step(); end
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom_range(0, 6), 0, '0, (i == 2));
      step();
    end
    idle_cycles(2);

    // Fill the shadow bank past capacity, then swap and probe the top end.
    for (int i = 0; i < PN; i++) begin drive(0, 0, 1, rand_word(), 0); step(); end
    drive(0, 0, 1, rand_word(), 0); step();
    do_swap();
    drive(1, PN - 1, 0, '0, 0); step();
    drive(1, PN, 0, '0, 0); step();
    drive(1, 0, 0, '0, 0); step();
    drive(1, 255, 0, '0, 0); step();
    idle_cycles(1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 1),
            ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15),
            $urandom_range(0, 1), rand_word(), ($urandom_range(0, 19) == 0));
      step();
    end
    idle_cycles(3);

    // Reset during a read and during DRAIN: no swap_done or rd_valid afterwards.
    do_reset();
    drive(0, 0, 1, rand_word(), 0); step();
    drive(1, 1, 0, '0, 1); step();
    drive(0, 0, 0, '0, 0);
    #2;
    do_reset();
    idle_cycles(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/velocity_cell_dbuf.md
VELOCITY_CELL_DBUF -- requirements
Module: velocity_cell_dbuf

Interface
REQ-001 Parameter DATA_WIDTH, default 96, width of one velocity word laid out as {vz, vy, vx}, each 32-bit float.
REQ-002 Parameter PARTICLE_NUM, default 220, number of words per bank; address 0 is reserved, so at most PARTICLE_NUM-1 particles.
REQ-003 Parameter ADDR_WIDTH, default 8, width of rd_addr; ADDR_WIDTH SHALL satisfy 2^ADDR_WIDTH >= PARTICLE_NUM.
REQ-004 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rd_en  in  1  read request; accepted only when rd_ready=1.
REQ-007 rd_addr  in  ADDR_WIDTH  read address into the active bank.
REQ-008 rd_ready  out  1  high only in state IDLE.
REQ-009 rd_valid  out  1  one-cycle pulse, asserted the cycle after an accepted read.
REQ-010 rd_data  out  DATA_WIDTH  read result, valid while rd_valid=1.
REQ-011 wr_en  in  1  append request into the shadow bank.
REQ-012 wr_data  in  DATA_WIDTH  new velocity word {vz, vy, vx}.
REQ-013 wr_ready  out  1  high when state=IDLE and the shadow bank is not full.
REQ-014 swap_req  in  1  single-cycle request to promote the shadow bank to active.
REQ-015 swap_done  out  1  one-cycle pulse when a swap completes.
REQ-016 active_bank  out  1  index (0 or 1) of the active bank.
REQ-017 active_count  out  ADDR_WIDTH  number of particles in the active bank.
REQ-018 overflow  out  1  sticky flag: a write was attempted while the shadow bank was full.

Function
REQ-019 The block SHALL hold two banks of PARTICLE_NUM words; reads address only the active bank and writes address only the shadow bank.
REQ-020 Read latency is exactly 1 cycle from an accepted rd_en to rd_valid/rd_data; back-to-back reads every cycle SHALL be supported.
REQ-021 A read of rd_addr=0 SHALL return active_count zero-extended to DATA_WIDTH.
REQ-022 A read of rd_addr > active_count SHALL return all-zero data with rd_valid=1.
REQ-023 rd_en while rd_ready=0 SHALL be ignored: no rd_valid pulse and rd_data unchanged.
REQ-024 The shadow write pointer SHALL start at 1; each accepted write (wr_en & wr_ready) SHALL store wr_data at the pointer, then increment the pointer.
REQ-025 The shadow bank is full when the pointer equals PARTICLE_NUM; wr_en while full SHALL be dropped and SHALL set overflow.
REQ-026 wr_en in any state other than IDLE SHALL be dropped without setting overflow.
REQ-027 FSM states and transitions:
- IDLE -> DRAIN on swap_req.
- DRAIN -> SWAP after one cycle, letting any in-flight read complete.
- SWAP -> IDLE after one cycle.
REQ-028 In SWAP the block SHALL:
- toggle active_bank;
- load active_count with (pointer - 1);
- reset the pointer to 1;
- pulse swap_done in the same cycle the new values become visible.
REQ-029 swap_req outside IDLE SHALL be ignored.
REQ-030 swap_req and wr_en in the same IDLE cycle: the write SHALL be accepted into the old shadow bank and counted before the swap.
REQ-031 A swap with zero writes SHALL produce active_count=0.
REQ-032 Timing and storage constraints:
- Each bank SHALL map to M20K with a registered output.
- Any internal read-during-write hazard is excluded by the bank separation.
- No combinational path SHALL exist from any input to any output.

Reset
REQ-033 On rst the block SHALL force:
- state=IDLE, active_bank=0, active_count=0, pointer=1;
- overflow=0, rd_valid=0, swap_done=0, rd_data=0.
REQ-034 Memory contents SHALL NOT be cleared on reset; REQ-022 keeps stale data unobservable.
REQ-035 rst asserted mid-swap or mid-read SHALL abort the operation with no swap_done and no rd_valid afterwards.

Verification
REQ-036 After reset, read addresses 0 and 5 -> two rd_valid pulses, both data=0.
REQ-037 Write 3 words A, B, C, pulse swap_req -> swap_done exactly 3 cycles later, active_bank=1, active_count=3; reads of addresses 1..3 -> A, B, C; read of address 0 -> 3; read of address 4 -> 0.
REQ-038 Write PARTICLE_NUM words -> the first PARTICLE_NUM-1 are accepted, wr_ready=0 after the last accepted write, overflow=1; after swap, active_count=PARTICLE_NUM-1.
REQ-039 Continuous reads every cycle while swap_req is pulsed -> rd_ready=0 during DRAIN/SWAP; every accepted read returns old-bank data; no rd_valid for rejected reads.
REQ-040 swap_req together with a wr_en of D in the same cycle -> D is included and active_count = previous writes + 1; a second swap_req during DRAIN is ignored.
REQ-041 rst asserted in DRAIN -> no swap_done, active_bank=0, active_count=0.
